// File: rtl/avalon_adapter_pkg.sv
// Shared types for the pipelined Avalon-MM register adapter: response codes,
// command flag bundle and the helpers that classify a command at the strobe stage.
package avalon_adapter_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY        = 2'b00,
      RESP_DECODEERROR = 2'b11
   } avalon_resp_t;

   // Control part of a pipeline stage; the top wraps it with address/lanes/data
   // because those widths depend on the instance parameters.
   typedef struct packed {
      logic rd;
      logic wr;
      logic decode_ok;
   } cmd_flags_t;

   // A read that collides with a write is dropped; the write side still executes.
   function automatic logic cmd_is_read(input cmd_flags_t f);
      return f.rd & ~f.wr;
   endfunction

   // Decode error and collision in the same command count as a single event.
   function automatic logic cmd_is_error(input cmd_flags_t f);
      return ((f.rd | f.wr) & ~f.decode_ok) | (f.rd & f.wr);
   endfunction

endpackage

// File: rtl/avalon_cmd_pipe.sv
// Delay line for one packed command word. DEPTH = 0 is a wire; otherwise every
// stage clears asynchronously so in-flight commands vanish on reset.
module avalon_cmd_pipe #(
   parameter type T     = logic,
   parameter int  DEPTH = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  T     d_i,
   output T     q_o
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign q_o = d_i;
      end else begin : g_stages
         T stage_q [DEPTH];

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage_q[i] <= '0;
               end
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < DEPTH; i++) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/avalon_pipelined_register_adapter.sv
// Fixed-latency Avalon-MM slave in front of a flat register bank: per-register
// strobes at stage LATENCY-1, registered read response one cycle later.
module avalon_pipelined_register_adapter
   import avalon_adapter_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGS      = 4,
   parameter int LATENCY       = 2,
   parameter int ADDR_WIDTH    = $clog2(NUM_REGS),
   parameter int BE_WIDTH      = DATA_WIDTH / 8,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           read,
   input  logic                           write,
   input  logic [ADDR_WIDTH-1:0]          address,
   input  logic [BE_WIDTH-1:0]            byteenable,
   input  logic [DATA_WIDTH-1:0]          writedata,
   output logic [DATA_WIDTH-1:0]          readdata,
   output logic                           readdatavalid,
   output logic [1:0]                     response,
   output logic [NUM_REGS-1:0]            reg_write_en,
   output logic [NUM_REGS-1:0]            reg_read_en,
   output logic [BE_WIDTH-1:0]            reg_byteenable,
   output logic [DATA_WIDTH-1:0]          reg_wdata,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rdata,
   output logic [ERR_CNT_WIDTH-1:0]       err_count
);

   typedef struct packed {
      cmd_flags_t              flags;
      logic [ADDR_WIDTH-1:0]   addr;
      logic [BE_WIDTH-1:0]     be;
      logic [DATA_WIDTH-1:0]   wdata;
   } cmd_t;

   // One extra address bit so the compare also works when NUM_REGS is a power of two.
   localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

   cmd_t cmd_in;
   cmd_t cmd_s;

   always_comb begin
      cmd_in                 = '0;
      cmd_in.flags.rd        = read;
      cmd_in.flags.wr        = write;
      cmd_in.flags.decode_ok = ({1'b0, address} < NUM_REGS_W);
      cmd_in.addr            = address;
      cmd_in.be              = byteenable;
      cmd_in.wdata           = writedata;
   end

   avalon_cmd_pipe #(
      .T     (cmd_t),
      .DEPTH (LATENCY - 1)
   ) u_cmd_pipe (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .d_i    (cmd_in),
      .q_o    (cmd_s)
   );

   logic                     wr_fire;
   logic                     rd_fire;
   logic                     rd_err;
   logic                     err_evt;
   logic [DATA_WIDTH-1:0]    rdata_sel;

   // Qualifying with reset_n keeps the bypass (LATENCY = 1) strobes quiet in reset.
   always_comb begin
      wr_fire      = reset_n & cmd_s.flags.wr & cmd_s.flags.decode_ok;
      rd_fire      = reset_n & cmd_is_read(cmd_s.flags) & cmd_s.flags.decode_ok;
      rd_err       = reset_n & cmd_is_read(cmd_s.flags) & ~cmd_s.flags.decode_ok;
      err_evt      = reset_n & cmd_is_error(cmd_s.flags);
      reg_write_en = '0;
      reg_read_en  = '0;
      rdata_sel    = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (cmd_s.addr == ADDR_WIDTH'(i)) begin
            reg_write_en[i] = wr_fire;
            reg_read_en[i]  = rd_fire;
            rdata_sel       = reg_rdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign reg_byteenable = wr_fire ? cmd_s.be    : '0;
   assign reg_wdata      = wr_fire ? cmd_s.wdata : '0;

   logic [DATA_WIDTH-1:0]    readdata_q, readdata_d;
   logic                     rdv_q, rdv_d;
   avalon_resp_t             resp_q, resp_d;
   logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

   always_comb begin
      readdata_d = readdata_q;
      if (rd_fire) begin
         readdata_d = rdata_sel;
      end else if (rd_err) begin
         readdata_d = '0;
      end
      rdv_d  = rd_fire | rd_err;
      resp_d = rd_err ? RESP_DECODEERROR : RESP_OKAY;
      err_d  = err_q;
      if (err_evt && (err_q != '1)) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_q <= '0;
         rdv_q      <= 1'b0;
         resp_q     <= RESP_OKAY;
         err_q      <= '0;
      end else begin
         readdata_q <= readdata_d;
         rdv_q      <= rdv_d;
         resp_q     <= resp_d;
         err_q      <= err_d;
      end
   end

   assign readdata      = readdata_q;
   assign readdatavalid = rdv_q;
   assign response      = resp_q;
   assign err_count     = err_q;

endmodule

// File: tb/tb_avalon_pipelined_register_adapter.sv
// Three adapters (LATENCY 2/1/4, NUM_REGS 5) share one stimulus bus; directed
// commands push expected strobes/responses into queues that a negedge monitor drains.
module tb_avalon_pipelined_register_adapter;

   localparam int DW = 32;
   localparam int NR = 5;
   localparam int AW = 3;
   localparam int BW = 4;
   localparam int ND = 3;

   function automatic int lat(input int d);
      return (d == 0) ? 2 : (d == 1) ? 1 : 4;
   endfunction

   logic            clk;
   logic            reset_n;
   logic            read, write;
   logic [AW-1:0]   address;
   logic [BW-1:0]   byteenable;
   logic [DW-1:0]   writedata;
   logic [NR*DW-1:0] reg_rdata;

   logic [DW-1:0]   rdata_o [ND];
   logic            rdv_o   [ND];
   logic [1:0]      resp_o  [ND];
   logic [NR-1:0]   wen_o   [ND];
   logic [NR-1:0]   ren_o   [ND];
   logic [BW-1:0]   rbe_o   [ND];
   logic [DW-1:0]   rwd_o   [ND];
   logic [7:0]      err_o   [ND];
   logic [1:0]      err_narrow;

   assign err_o[0] = {6'b0, err_narrow};
   assign reg_rdata = {32'h80000001, 32'h0000FFFF, 32'hCAFEF00D, 32'h12345678, 32'h11110000};

   avalon_pipelined_register_adapter #(.DATA_WIDTH(DW), .NUM_REGS(NR), .LATENCY(2), .ERR_CNT_WIDTH(2)) dut_l2 (
      .clk(clk), .reset_n(reset_n), .read(read), .write(write), .address(address),
      .byteenable(byteenable), .writedata(writedata), .readdata(rdata_o[0]), .readdatavalid(rdv_o[0]),
      .response(resp_o[0]), .reg_write_en(wen_o[0]), .reg_read_en(ren_o[0]), .reg_byteenable(rbe_o[0]),
      .reg_wdata(rwd_o[0]), .reg_rdata(reg_rdata), .err_count(err_narrow));

   avalon_pipelined_register_adapter #(.DATA_WIDTH(DW), .NUM_REGS(NR), .LATENCY(1), .ERR_CNT_WIDTH(8)) dut_l1 (
      .clk(clk), .reset_n(reset_n), .read(read), .write(write), .address(address),
      .byteenable(byteenable), .writedata(writedata), .readdata(rdata_o[1]), .readdatavalid(rdv_o[1]),
      .response(resp_o[1]), .reg_write_en(wen_o[1]), .reg_read_en(ren_o[1]), .reg_byteenable(rbe_o[1]),
      .reg_wdata(rwd_o[1]), .reg_rdata(reg_rdata), .err_count(err_o[1]));

   avalon_pipelined_register_adapter #(.DATA_WIDTH(DW), .NUM_REGS(NR), .LATENCY(4), .ERR_CNT_WIDTH(8)) dut_l4 (
      .clk(clk), .reset_n(reset_n), .read(read), .write(write), .address(address),
      .byteenable(byteenable), .writedata(writedata), .readdata(rdata_o[2]), .readdatavalid(rdv_o[2]),
      .response(resp_o[2]), .reg_write_en(wen_o[2]), .reg_read_en(ren_o[2]), .reg_byteenable(rbe_o[2]),
      .reg_wdata(rwd_o[2]), .reg_rdata(reg_rdata), .err_count(err_o[2]));

   typedef struct packed { int cyc; logic [NR-1:0] en; logic [BW-1:0] be; logic [DW-1:0] data; } wexp_t;
   typedef struct packed { int cyc; logic [NR-1:0] en; } rexp_t;
   typedef struct packed { int cyc; logic [DW-1:0] data; logic [1:0] resp; } pexp_t;

   wexp_t wq [ND][$];
   rexp_t rq [ND][$];
   pexp_t pq [ND][$];

   int   cyc;
   int   n_cmp;
   int   n_fail;
   logic mon_en;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, d, cyc, act, exp);
      end
   endtask

   function automatic logic [127:0] all_outs(input int d);
      return {39'b0, rdv_o[d], resp_o[d], rdata_o[d], wen_o[d], ren_o[d], rbe_o[d], rwd_o[d], err_o[d]};
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < ND; d++) begin
            if (wq[d].size() != 0 && wq[d][0].cyc <= cyc) begin
               chk("wr_strobe", d, {wen_o[d], rbe_o[d], rwd_o[d]},
                   (wq[d][0].cyc == cyc) ? {wq[d][0].en, wq[d][0].be, wq[d][0].data} : 128'hDEAD);
               void'(wq[d].pop_front());
            end else begin
               chk("wr_idle", d, {wen_o[d], rbe_o[d], rwd_o[d]}, '0);
            end
            if (rq[d].size() != 0 && rq[d][0].cyc <= cyc) begin
               chk("rd_strobe", d, ren_o[d], (rq[d][0].cyc == cyc) ? rq[d][0].en : 5'h1F);
               void'(rq[d].pop_front());
            end else begin
               chk("rd_idle", d, ren_o[d], '0);
            end
            if (pq[d].size() != 0 && pq[d][0].cyc <= cyc) begin
               chk("rd_resp", d, {rdv_o[d], resp_o[d], rdata_o[d]},
                   (pq[d][0].cyc == cyc) ? {1'b1, pq[d][0].resp, pq[d][0].data} : 128'hDEAD);
               void'(pq[d].pop_front());
            end else begin
               chk("rdv_idle", d, rdv_o[d], 1'b0);
            end
         end
      end
   end

   task automatic cmd(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] be,
                      input logic [DW-1:0] wd, input logic [NR-1:0] xw, input logic [NR-1:0] xr,
                      input logic xv, input logic [DW-1:0] xd, input logic [1:0] xresp);
      wexp_t w;
      rexp_t r;
      pexp_t p;
      @(posedge clk);
      #1;
      read = rd; write = wr; address = a; byteenable = be; writedata = wd;
      for (int d = 0; d < ND; d++) begin
         if (xw != '0) begin
            w.cyc = cyc + lat(d) - 1; w.en = xw; w.be = be; w.data = wd;
            wq[d].push_back(w);
         end
         if (xr != '0) begin
            r.cyc = cyc + lat(d) - 1; r.en = xr;
            rq[d].push_back(r);
         end
         if (xv) begin
            p.cyc = cyc + lat(d); p.data = xd; p.resp = xresp;
            pq[d].push_back(p);
         end
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      read = 1'b0; write = 1'b0; address = '0; byteenable = '0; writedata = '0;
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic check_err(input logic [7:0] x_narrow, input logic [7:0] x_wide);
      idle(6);
      @(negedge clk);
      chk("err_count", 0, err_o[0], x_narrow);
      chk("err_count", 1, err_o[1], x_wide);
      chk("err_count", 2, err_o[2], x_wide);
   endtask

   initial begin
      cyc = 0; n_cmp = 0; n_fail = 0; mon_en = 1'b0;
      reset_n = 1'b0;
      read = 1'b0; write = 1'b0; address = '0; byteenable = '0; writedata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < ND; d++) chk("reset_outputs", d, all_outs(d), '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // rd wr addr be wdata xwen xren xrdv xrdata xresp
      cmd(0, 1, 3'd2, 4'hF, 32'hDEADBEEF, 5'b00100, 5'b00000, 0, 32'h0, 2'b00);
      cmd(1, 0, 3'd1, 4'h0, 32'h0,        5'b00000, 5'b00010, 1, 32'h12345678, 2'b00);
      cmd(1, 0, 3'd0, 4'h0, 32'h0,        5'b00000, 5'b00001, 1, 32'h11110000, 2'b00);
      cmd(1, 0, 3'd1, 4'h0, 32'h0,        5'b00000, 5'b00010, 1, 32'h12345678, 2'b00);
      cmd(1, 0, 3'd2, 4'h0, 32'h0,        5'b00000, 5'b00100, 1, 32'hCAFEF00D, 2'b00);
      cmd(1, 0, 3'd3, 4'h0, 32'h0,        5'b00000, 5'b01000, 1, 32'h0000FFFF, 2'b00);
      cmd(1, 0, 3'd4, 4'h0, 32'h0,        5'b00000, 5'b10000, 1, 32'h80000001, 2'b00);
      cmd(0, 1, 3'd3, 4'h0, 32'h01020304, 5'b01000, 5'b00000, 0, 32'h0, 2'b00);
      cmd(0, 1, 3'd4, 4'h9, 32'h55AA55AA, 5'b10000, 5'b00000, 0, 32'h0, 2'b00);
      check_err(8'd0, 8'd0);

      cmd(1, 0, 3'd6, 4'h0, 32'h0,        5'b00000, 5'b00000, 1, 32'h0, 2'b11);
      check_err(8'd1, 8'd1);
      cmd(0, 1, 3'd7, 4'hF, 32'hFFFFFFFF, 5'b00000, 5'b00000, 0, 32'h0, 2'b00);
      check_err(8'd2, 8'd2);
      cmd(1, 1, 3'd0, 4'h3, 32'hA5A5A5A5, 5'b00001, 5'b00000, 0, 32'h0, 2'b00);
      check_err(8'd3, 8'd3);
      cmd(1, 1, 3'd5, 4'hF, 32'h12121212, 5'b00000, 5'b00000, 0, 32'h0, 2'b00);
      check_err(8'd3, 8'd4);
      cmd(1, 0, 3'd7, 4'h0, 32'h0,        5'b00000, 5'b00000, 1, 32'h0, 2'b11);
      cmd(1, 0, 3'd2, 4'h0, 32'h0,        5'b00000, 5'b00100, 1, 32'hCAFEF00D, 2'b00);
      check_err(8'd3, 8'd5);

      // Reads left in flight across a reset pulse must never surface.
      idle(8);
      mon_en = 1'b0;
      cmd(1, 0, 3'd1, 4'h0, 32'h0, 5'b00000, 5'b00000, 0, 32'h0, 2'b00);
      cmd(1, 0, 3'd2, 4'h0, 32'h0, 5'b00000, 5'b00000, 0, 32'h0, 2'b00);
      cmd(1, 0, 3'd3, 4'h0, 32'h0, 5'b00000, 5'b00000, 0, 32'h0, 2'b00);
      @(posedge clk);
      #1;
      read = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      for (int d = 0; d < ND; d++) chk("reset_mid", d, all_outs(d), '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      mon_en  = 1'b1;
      check_err(8'd0, 8'd0);
      idle(4);
      cmd(1, 0, 3'd4, 4'h0, 32'h0, 5'b00000, 5'b10000, 1, 32'h80000001, 2'b00);
      idle(8);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk("queue_drain", d, {wq[d].size(), rq[d].size(), pq[d].size()}, '0);
      end
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
